mem_access_unit: RTL and testbench

- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the ALU address, store data and memory control from EX/MEM, and runs a request/acknowledge transaction on the data-memory bus.
- Stalls the pipeline while the access is outstanding.
- Delivers aligned, sign- or zero-extended load data on dm_data_out, which feeds the MEM/WB register's DM data input.
- Supports byte, halfword and word accesses, variable-latency memory, a bus timeout and misalignment detection.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access controller
// Runs one req/ack bus transaction per aligned load/store and stalls the pipeline meanwhile.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_in,
    input  logic        mem_w_in,
    input  logic [2:0]  mem_op_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [31:0] dm_data_out,
    output logic        mem_stall,
    output logic        align_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [1:0]       r_lane;

    logic        w_acc;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_misal;
    logic        w_start;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    // op[1:0] selects size; 01x/11x all fall through to word
    assign w_acc     = mem_r_in | mem_w_in;
    assign w_is_byte = (mem_op_in[1:0] == 2'b00);
    assign w_is_half = (mem_op_in[1:0] == 2'b01);
    assign w_misal   = (w_is_half & addr_in[0]) |
                       (~w_is_byte & ~w_is_half & (addr_in[1:0] != 2'b00));
    assign align_err = (r_state == S_IDLE) & w_acc & w_misal;
    assign w_start   = (r_state == S_IDLE) & w_acc & ~w_misal;
    assign mem_stall = ~rst & (w_start | (r_state == S_REQ));
    assign w_timeout = ~dm_ack & (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_in;
        if (w_is_byte) begin
            w_be    = 4'b0001 << addr_in[1:0];
            w_wdata = {4{wdata_in[7:0]}};
        end else if (w_is_half) begin
            w_be    = addr_in[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wdata_in[15:0]}};
        end
        if (!mem_w_in) begin
            w_be = 4'b1111;
        end
    end

    always_comb begin
        w_byte = 8'(dm_rdata >> {r_lane, 3'b000});
        w_half = r_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_size)
            2'd0:    w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'd1:    w_ext = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ext = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ:   if (dm_ack | w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus fields are latched once at launch so they stay stable while dm_req is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 32'd0;
            dm_be       <= 4'd0;
            dm_wdata    <= 32'd0;
            dm_data_out <= 32'd0;
            bus_err     <= 1'b0;
            r_cnt       <= '0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
            r_lane      <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        dm_req   <= 1'b1;
                        dm_we    <= mem_w_in;
                        dm_addr  <= {addr_in[31:2], 2'b00};
                        dm_be    <= w_be;
                        dm_wdata <= w_wdata;
                        r_size   <= w_is_byte ? 2'd0 : (w_is_half ? 2'd1 : 2'd2);
                        r_uns    <= mem_op_in[2];
                        r_lane   <= addr_in[1:0];
                        r_cnt    <= '0;
                    end
                end
                S_REQ: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) dm_data_out <= w_ext;
                    end else if (w_timeout) begin
                        dm_req  <= 1'b0;
                        bus_err <= 1'b1;
                        if (!dm_we) dm_data_out <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  bus_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// Directed test-plan steps followed by random accesses scored against an arithmetic model.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_in = 1'b0;
    logic        mem_w_in = 1'b0;
    logic [2:0]  mem_op_in = 3'b000;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = 32'd0;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_data_out;
    logic        mem_stall;
    logic        align_err;
    logic        bus_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_dout = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_r_in(mem_r_in), .mem_w_in(mem_w_in), .mem_op_in(mem_op_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .dm_data_out(dm_data_out), .mem_stall(mem_stall),
        .align_err(align_err), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic m_misal(input logic [2:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) % nbytes(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] addr, input logic store);
        if (!store || nbytes(op) == 4) return 4'hF;
        return 4'(((1 << nbytes(op)) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
        case (nbytes(op))
            1:       return 32'(wd[7:0]) * 32'h0101_0101;
            2:       return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd);
        int n;
        logic [31:0] v;
        logic [31:0] mask;
        n = nbytes(op);
        if (n == 4) return rd;
        v = rd >> (8 * addr[1:0]);
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = v & mask;
        if (!op[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // waits = REQ cycles without ack before the ack; waits >= TIMEOUT means never ack
    task automatic access(input logic r, input logic w, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits, input string tag);
        logic acc;
        logic mis;
        logic tmo;
        int exp_req;
        int n_req;
        int n_stall;
        logic [31:0] ea;
        logic [3:0] eb;
        logic [31:0] ewd;
        acc = r | w;
        mis = acc & m_misal(op, addr);
        tmo = (waits >= TIMEOUT);
        mem_r_in = r; mem_w_in = w; mem_op_in = op; addr_in = addr; wdata_in = wd;
        #1;
        chk({tag, " align_err"}, align_err, mis);
        chk({tag, " stall_idle"}, mem_stall, acc & ~mis);
        if (!acc || mis) begin
            @(posedge clk); #1;
            chk({tag, " noreq"}, dm_req, 1'b0);
            chk({tag, " nostall"}, mem_stall, 1'b0);
            chk({tag, " dout_hold"}, dm_data_out, exp_dout);
            mem_r_in = 1'b0; mem_w_in = 1'b0;
            return;
        end
        ea = {addr[31:2], 2'b00};
        eb = m_be(op, addr, w);
        ewd = m_wdata(op, wd);
        exp_req = tmo ? TIMEOUT : waits + 1;
        n_req = 0;
        n_stall = 1;
        @(posedge clk); #1;
        while (dm_req === 1'b1 && n_req < TIMEOUT + 4) begin
            chk({tag, " addr"}, dm_addr, ea);
            chk({tag, " be"}, dm_be, eb);
            chk({tag, " we"}, dm_we, w);
            if (w) chk({tag, " wdata"}, dm_wdata, ewd);
            n_stall += int'(mem_stall);
            if (n_req == waits) begin
                dm_ack = 1'b1; dm_rdata = rd;
            end else begin
                dm_ack = 1'b0; dm_rdata = $urandom;
            end
            n_req++;
            @(posedge clk); #1;
            dm_ack = 1'b0;
        end
        chk({tag, " req_cycles"}, n_req, exp_req);
        chk({tag, " stall_cycles"}, n_stall, exp_req + 1);
        chk({tag, " stall_done"}, mem_stall, 1'b0);
        chk({tag, " bus_err"}, bus_err, tmo);
        if (!w) exp_dout = tmo ? 32'd0 : m_load(op, addr, rd);
        chk({tag, " dout"}, dm_data_out, exp_dout);
        @(posedge clk); #1;
        mem_r_in = 1'b0; mem_w_in = 1'b0;
        #1;
        chk({tag, " bus_err_clr"}, bus_err, 1'b0);
        chk({tag, " idle_req"}, dm_req, 1'b0);
        chk({tag, " idle_stall"}, mem_stall, 1'b0);
    endtask

    initial begin
        logic [2:0] rop;
        logic [31:0] raddr;
        int rwait;

        // Reset state, with a request presented while rst is high
        mem_r_in = 1'b1; mem_op_in = 3'b010; addr_in = 32'h100;
        @(posedge clk); #1;
        chk("rst dm_req", dm_req, 1'b0);
        chk("rst dm_we", dm_we, 1'b0);
        chk("rst dm_addr", dm_addr, 32'd0);
        chk("rst dm_be", dm_be, 4'd0);
        chk("rst dm_wdata", dm_wdata, 32'd0);
        chk("rst dout", dm_data_out, 32'd0);
        chk("rst bus_err", bus_err, 1'b0);
        chk("rst stall", mem_stall, 1'b0);
        mem_r_in = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, "LB");
        access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'h8001_0000, 0, "LHU");
        access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h8001_0000, 1, "LH");
        access(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, "SH");
        access(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, 32'd0, 5, "SW");
        access(1'b1, 1'b0, 3'b100, 32'h0000_7001, 32'd0, 32'h0000_9900, 0, "LBU");
        access(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'h1111_2222, TIMEOUT, "TMO");
        access(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'd0, 32'd0, 0, "LW_MIS");
        access(1'b1, 1'b1, 3'b000, 32'h0000_8001, 32'h0000_00A5, 32'd0, 2, "BOTH");

        // Reset during REQ, then a stray ack in IDLE
        mem_r_in = 1'b1; mem_op_in = 3'b010; addr_in = 32'h0000_9000;
        @(posedge clk); #1;
        chk("midrst req_up", dm_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst dm_req", dm_req, 1'b0);
        chk("midrst dm_addr", dm_addr, 32'd0);
        chk("midrst dm_be", dm_be, 4'd0);
        chk("midrst stall", mem_stall, 1'b0);
        chk("midrst dout", dm_data_out, 32'd0);
        exp_dout = 32'd0;
        mem_r_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("late_ack req", dm_req, 1'b0);
        chk("late_ack dout", dm_data_out, 32'd0);
        chk("late_ack bus_err", bus_err, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            raddr = $urandom;
            if ($urandom_range(0, 1) == 0) raddr[1:0] = 2'b00;
            rwait = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
            access(1'($urandom), 1'($urandom), rop, raddr, $urandom, $urandom, rwait, "RND");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
